// File: rtl/cdc_pkg.sv
// cdc_pkg: state encoding and defaults shared by the crossing-bus arbiter
package cdc_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-stage flop chain bringing asynchronous bits into the CLK domain
module bit_sync #(
  parameter int STAGES_NUM = 2,
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES_NUM-1:0][WIDTH-1:0] sr;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) sr <= '0;
    else sr <= {sr[STAGES_NUM-2:0], d};
  assign q = sr[STAGES_NUM-1];
endmodule

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: round-robin arbiter sending one payload at a time over a four-phase crossing bus
module cdc_tx_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BUS_WIDTH = 8,
  parameter int STAGES_NUM = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  input  logic                         ack_async,
  output logic [BUS_WIDTH-1:0]         async_bus,
  output logic                         async_bus_en,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           err,
  output logic                         busy
);
  localparam int IW = $clog2(NUM_REQ);
  logic [1:0] state;
  logic [IW-1:0] ptr, win, sel, nxt_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [9:0] cnt;
  logic sel_v, ack_s, tmo;
  bit_sync #(.STAGES_NUM(STAGES_NUM), .WIDTH(1)) u_ack_sync (
    .CLK(CLK),
    .RST(RST),
    .d(ack_async),
    .q(ack_s)
  );
  // scan downward so the requester closest above ptr is the last, winning assignment
  always_comb begin
    sel_v = 1'b0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        sel_v = 1'b1;
        sel = IW'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign nxt_ptr = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  assign win_oh = NUM_REQ'(1) << win;
  assign tmo = cnt == 10'(TIMEOUT - 1);
  assign busy = state != ST_IDLE;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= ST_IDLE;
      ptr <= '0;
      win <= '0;
      cnt <= '0;
      async_bus <= '0;
      async_bus_en <= 1'b0;
      done <= '0;
      err <= '0;
    end else begin
      done <= '0;
      err <= '0;
      cnt <= (state == ST_SEND || state == ST_RELEASE) ? cnt + 1'b1 : '0;
      case (state)
        ST_IDLE:
          if (sel_v && !ack_s) begin
            async_bus <= req_data[sel*BUS_WIDTH +: BUS_WIDTH];
            async_bus_en <= 1'b1;
            win <= sel;
            cnt <= '0;
            state <= ST_SEND;
          end
        ST_SEND:
          if (ack_s) begin
            async_bus_en <= 1'b0;
            cnt <= '0;
            state <= ST_RELEASE;
          end else if (tmo) begin
            async_bus_en <= 1'b0;
            err <= win_oh;
            ptr <= nxt_ptr;
            cnt <= '0;
            state <= ST_RECOVER;
          end
        ST_RELEASE:
          if (!ack_s) begin
            done <= win_oh;
            ptr <= nxt_ptr;
            cnt <= '0;
            state <= ST_IDLE;
          end else if (tmo) begin
            err <= win_oh;
            ptr <= nxt_ptr;
            cnt <= '0;
            state <= ST_RECOVER;
          end
        default:
          if (!ack_s) state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb_cdc_tx_arbiter: directed table-driven bench for the crossing-bus arbiter
module tb_cdc_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] bus;
    logic [N-1:0] done;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = 32'h4433_A511;
  logic ack_async;
  logic [W-1:0] async_bus;
  logic async_bus_en;
  logic [N-1:0] done, err;
  logic busy;
  logic auto_ack = 1'b1;
  logic ack_man = 1'b0;
  logic [2:0] hist = '0;
  int checks = 0;
  int errors = 0;
  vec_t tbl [9];

  cdc_tx_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .STAGES_NUM(2), .TIMEOUT(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .req(req),
    .req_data(req_data),
    .ack_async(ack_async),
    .async_bus(async_bus),
    .async_bus_en(async_bus_en),
    .done(done),
    .err(err),
    .busy(busy)
  );

  always #5 CLK = ~CLK;
  // destination model: acknowledge follows the request three half-cycle samples later
  always @(negedge CLK) hist = {hist[1:0], async_bus_en};
  assign ack_async = auto_ack ? hist[2] : ack_man;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_en();
    int n = 0;
    while (!async_bus_en && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("en_rise", 32'(async_bus_en), 32'd1);
  endtask

  task automatic wait_pulse(output logic [N-1:0] d, output logic [N-1:0] e);
    int n = 0;
    while (done == '0 && err == '0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    d = done;
    e = err;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] d, e;
    int n;
    tbl[0] = '{4'b1111, 8'h11, 4'b0001};
    tbl[1] = '{4'b1111, 8'hA5, 4'b0010};
    tbl[2] = '{4'b1111, 8'h33, 4'b0100};
    tbl[3] = '{4'b1111, 8'h44, 4'b1000};
    tbl[4] = '{4'b1111, 8'h11, 4'b0001};
    tbl[5] = '{4'b1001, 8'h44, 4'b1000};
    tbl[6] = '{4'b0110, 8'hA5, 4'b0010};
    tbl[7] = '{4'b0011, 8'h11, 4'b0001};
    tbl[8] = '{4'b0100, 8'h33, 4'b0100};
    #2 RST = 1'b0;
    #1;
    chk("rst_en", 32'(async_bus_en), 32'd0);
    chk("rst_bus", 32'(async_bus), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    // single request, dropped right after selection
    req = 4'b0010;
    @(posedge CLK);
    #1;
    chk("single_en", 32'(async_bus_en), 32'd1);
    chk("single_bus", 32'(async_bus), 32'hA5);
    chk("single_busy", 32'(busy), 32'd1);
    req = '0;
    wait_pulse(d, e);
    chk("single_done", 32'(d), 32'b0010);
    chk("single_err", 32'(e), 32'd0);
    @(negedge CLK);
    chk("single_done_once", 32'(done), 32'd0);
    repeat (2) @(negedge CLK);
    chk("single_idle", 32'(busy), 32'd0);
    do_reset();
    // round-robin sequence from ptr=0
    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req;
      wait_en();
      chk($sformatf("rr%0d_bus", i), 32'(async_bus), 32'(tbl[i].bus));
      wait_pulse(d, e);
      chk($sformatf("rr%0d_done", i), 32'(d), 32'(tbl[i].done));
      chk($sformatf("rr%0d_err", i), 32'(e), 32'd0);
    end
    req = '0;
    // send timeout with no acknowledge; ptr=3 so requester 0 then 2
    auto_ack = 1'b0;
    ack_man = 1'b0;
    req = 4'b0101;
    wait_en();
    chk("tmo_bus", 32'(async_bus), 32'h11);
    n = 0;
    while (async_bus_en && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("tmo_en_cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(err), 32'b0001);
    chk("tmo_no_done", 32'(done), 32'd0);
    wait_en();
    chk("tmo_next_bus", 32'(async_bus), 32'h33);
    auto_ack = 1'b1;
    req = '0;
    wait_pulse(d, e);
    chk("tmo_next_done", 32'(d), 32'b0100);
    // acknowledge stuck high through release
    @(negedge CLK);
    auto_ack = 1'b0;
    ack_man = 1'b0;
    req = 4'b1000;
    wait_en();
    ack_man = 1'b1;
    req = '0;
    wait_pulse(d, e);
    chk("stuck_err", 32'(e), 32'b1000);
    chk("stuck_no_done", 32'(d), 32'd0);
    repeat (5) @(negedge CLK);
    chk("stuck_recover_busy", 32'(busy), 32'd1);
    chk("stuck_recover_en", 32'(async_bus_en), 32'd0);
    ack_man = 1'b0;
    repeat (4) @(negedge CLK);
    chk("stuck_idle", 32'(busy), 32'd0);
    // data stability, then reset mid-send; ptr=0 so requester 2 wins
    req = 4'b0100;
    wait_en();
    chk("hold_bus0", 32'(async_bus), 32'h33);
    req_data[23:16] = 8'hEE;
    req = '0;
    repeat (3) @(negedge CLK);
    chk("hold_bus1", 32'(async_bus), 32'h33);
    chk("hold_en", 32'(async_bus_en), 32'd1);
    RST = 1'b0;
    #1;
    chk("rstmid_en", 32'(async_bus_en), 32'd0);
    chk("rstmid_bus", 32'(async_bus), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge CLK);
      if (done != '0 || err != '0) n++;
    end
    chk("rstmid_no_pulse", 32'(n), 32'd0);
    // no start while acknowledge is still high in idle
    ack_man = 1'b1;
    repeat (4) @(negedge CLK);
    req = 4'b0001;
    repeat (4) @(negedge CLK);
    chk("ackhigh_no_start", 32'(async_bus_en), 32'd0);
    chk("ackhigh_idle", 32'(busy), 32'd0);
    ack_man = 1'b0;
    wait_en();
    chk("ackhigh_bus", 32'(async_bus), 32'h11);
    req = '0;
    auto_ack = 1'b1;
    wait_pulse(d, e);
    chk("ackhigh_done", 32'(d), 32'b0001);
    chk("ackhigh_err", 32'(e), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdc_tx_arbiter.md
CDC_TX_ARBITER -- requirements
Module: cdc_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of source-domain requesters (range 2..8).
REQ-002 Parameter BUS_WIDTH, default 8, SHALL set the width of the shared crossing bus.
REQ-003 Parameter STAGES_NUM, default 2, SHALL set the synchronizer depth for the returned acknowledge (minimum 2).
REQ-004 Parameter TIMEOUT, default 64, SHALL set the maximum cycles to wait for any acknowledge edge (range 8..1023).
REQ-005 CLK  input  1  SHALL be the source-domain clock; all logic is clocked on its rising edge.
REQ-006 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  SHALL be the per-requester level request.
REQ-008 req_data  input  NUM_REQ*BUS_WIDTH  SHALL be the per-requester payload; requester i uses slice [i*BUS_WIDTH +: BUS_WIDTH].
REQ-009 ack_async  input  1  SHALL be the destination-domain acknowledge, asynchronous to CLK.
REQ-010 async_bus  output  BUS_WIDTH  SHALL be the registered payload driven across the clock boundary.
REQ-011 async_bus_en  output  1  SHALL be the registered four-phase request toward the destination synchronizer.
REQ-012 done  output  NUM_REQ  SHALL give a one-hot, one-cycle pulse marking transfer completion for the served requester.
REQ-013 err  output  NUM_REQ  SHALL give a one-hot, one-cycle pulse marking a timed-out transfer for the served requester.
REQ-014 busy  output  1  SHALL be high whenever the state machine is not in IDLE.

Function
REQ-015 ack_async SHALL pass through a STAGES_NUM-deep flop chain before use, giving ack_s.
REQ-016 States SHALL be IDLE, SEND, RELEASE and RECOVER.
REQ-017 IDLE with any req bit high SHALL select a winner round-robin, searching upward from pointer ptr and wrapping at NUM_REQ-1 to 0.
REQ-018 On selection, async_bus SHALL load the winner's slice, async_bus_en SHALL be set to 1 and the state SHALL become SEND, all on the same edge (one cycle of latency from req to async_bus_en).
REQ-019 async_bus SHALL hold its value from selection until the next selection; requester data changes after selection SHALL be ignored.
REQ-020 SEND with ack_s=1 SHALL clear async_bus_en and enter RELEASE.
REQ-021 RELEASE with ack_s=0 SHALL pulse done[winner], set ptr to winner+1 (modulo NUM_REQ) and enter IDLE.
REQ-022 A cycle counter SHALL clear on every state change and increment in SEND and RELEASE.
REQ-023 When the counter reaches TIMEOUT-1 in SEND or RELEASE, the block SHALL clear async_bus_en, pulse err[winner], advance ptr as in REQ-021 and enter RECOVER.
REQ-024 RECOVER SHALL wait until ack_s=0, then enter IDLE; it SHALL not time out.
REQ-025 Deassertion of req by the winner mid-transfer SHALL not abort the transfer; done SHALL still pulse.
REQ-026 A requester holding req high SHALL be served again only after all other pending requesters have had one turn.
REQ-027 In IDLE, the block SHALL not start a new transfer while ack_s=1.
REQ-028 done and err SHALL never pulse in the same cycle.

Reset
REQ-029 RST low SHALL immediately force the state to IDLE, async_bus to 0, async_bus_en to 0, done to 0, err to 0, ptr to 0, the counter to 0 and the ack synchronizer to 0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer without a done or err pulse.

Structure
REQ-031 The state encoding and the default TIMEOUT SHALL live in the shared package cdc_pkg.
REQ-032 The ack synchronizer SHALL be a separate sub-module, bit_sync, parameterized by STAGES_NUM and width.

Verification
REQ-033 Single request: req=4'b0010, data1=8'hA5, ack_async looped back after 3 cycles -> async_bus=8'hA5 and async_bus_en=1 one cycle after req; done=4'b0010 once; busy returns to 0.
REQ-034 Contention: req=4'b1111 held, ptr=0 -> service order 0,1,2,3,0, with exactly one done pulse each.
REQ-035 Timeout: TIMEOUT=16, ack_async tied to 0 -> async_bus_en falls after 16 cycles in SEND; err[winner] pulses; the next requester is served.
REQ-036 Stuck acknowledge: ack_async held at 1 through RELEASE -> err pulses and the block stays in RECOVER until ack_async falls, then returns to IDLE.
REQ-037 Reset mid-SEND: RST low while async_bus_en=1 -> async_bus_en=0, async_bus=0 and busy=0 immediately; no done pulse.
REQ-038 Data stability: change req_data of the winner during SEND -> async_bus remains at the value latched at selection.
